// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the instruction at the current PC over a req/ack memory
// port, latches it into the instruction register and returns PC+PC_INC with a
// one-cycle PC load strobe. Supports flush/abort and a no-ack timeout fault.
module instr_fetch_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned PC_INC  = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              fetch_done,
  output logic              busy,
  output logic              fetch_fault
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Fetch control FSM; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      ir          <= '0;
      pc_next     <= '0;
      pc_write    <= 1'b0;
      fetch_done  <= 1'b0;
      busy        <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pc_write   <= 1'b0;
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start && !flush) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            // Abort wins over a same-cycle ack: no result, no PC load.
            imem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (imem_ack) begin
            ir         <= imem_rdata;
            pc_next    <= imem_addr + ADDR_W'(PC_INC);
            imem_req   <= 1'b0;
            pc_write   <= 1'b1;
            fetch_done <= 1'b1;
            state      <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          if (flush) begin
            fetch_fault <= 1'b0;
            state       <= IDLE;
          end else if (fetch_start) begin
            fetch_fault <= 1'b0;
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            busy        <= 1'b1;
            wait_cnt    <= '0;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a stimulus process pushes the expected
// {ir, pc_next} for every completing fetch; a monitor pops on each pc_write.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] ir;
  logic [15:0] pc_next;
  logic        pc_write;
  logic        fetch_done;
  logic        busy;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic        prev_pw = 1'b0;

  instr_fetch_unit #(
    .DATA_W(16), .ADDR_W(16), .PC_INC(2), .TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset), .fetch_start(fetch_start), .flush(flush),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .pc_next(pc_next), .pc_write(pc_write),
    .fetch_done(fetch_done), .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full fetch with 'waits' no-ack REQ cycles before the ack.
  task automatic fetch(input logic [15:0] a, input logic [15:0] d, input int waits);
    logic [15:0] nxt;
    nxt = a + 16'd2;
    pc = a;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("req_high", 32'(imem_req), 1);
      check("req_addr", 32'(imem_addr), 32'(a));
      check("busy_req", 32'(busy), 1);
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = d;
        exp_q.push_back({d, nxt});
      end
      tick();
    end
    imem_ack = 1'b0;
    check("req_low_done", 32'(imem_req), 0);
    check("pc_write_done", 32'(pc_write), 1);
    check("busy_done", 32'(busy), 1);
    tick();
    check("pc_write_drop", 32'(pc_write), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  // Scoreboard monitor: compare every completion against the expected queue.
  always @(negedge clock) begin
    if (!reset && pc_write) begin
      check("pc_write_single", 32'(prev_pw), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pc_write", 32'(pc_write), 0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("ir", 32'(ir), 32'(e[31:16]));
        check("pc_next", 32'(pc_next), 32'(e[15:0]));
        check("fetch_done", 32'(fetch_done), 1);
      end
    end
    prev_pw <= pc_write;
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_pc_next", 32'(pc_next), 0);
    check("rst_strobes", {30'd0, pc_write, fetch_done}, 0);
    check("rst_busy_fault", {30'd0, busy, fetch_fault}, 0);

    // Zero-wait, delayed and wrapping fetches.
    fetch(16'h0010, 16'hA5C3, 0);
    fetch(16'h0100, 16'hBEEF, 3);
    fetch(16'hFFFE, 16'h1234, 0);

    // Flush and ack in the same REQ cycle.
    pc = 16'h0200;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("flush_req_high", 32'(imem_req), 1);
    flush = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    flush = 1'b0;
    imem_ack = 1'b0;
    check("flush_req_low", 32'(imem_req), 0);
    check("flush_busy", 32'(busy), 0);
    check("flush_no_pw", 32'(pc_write), 0);
    check("flush_ir_kept", 32'(ir), 32'h1234);
    check("flush_pc_next_kept", 32'(pc_next), 0);
    tick();
    check("flush_no_done", 32'(fetch_done), 0);

    // Timeout after TIMEOUT=4 REQ cycles, then recovery.
    pc = 16'h0300;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_req_high", 32'(imem_req), 1);
      check("to_no_fault_yet", 32'(fetch_fault), 0);
      tick();
    end
    check("to_fault", 32'(fetch_fault), 1);
    check("to_req_low", 32'(imem_req), 0);
    check("to_busy_low", 32'(busy), 0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("fault_sticky", 32'(fetch_fault), 1);
    check("fault_ack_ignored", 32'(pc_write), 0);
    fetch(16'h0300, 16'h5A5A, 1);
    check("fault_cleared", 32'(fetch_fault), 0);

    // Flush in FAULT clears the flag.
    pc = 16'h0320;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("to2_fault", 32'(fetch_fault), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clears_fault", 32'(fetch_fault), 0);
    check("flush_fault_req", 32'(imem_req), 0);

    // Start pulses during REQ are ignored.
    pc = 16'h0400;
    fetch_start = 1'b1;
    tick();
    check("ign_addr", 32'(imem_addr), 32'h0400);
    pc = 16'h0500;
    tick();
    check("ign_addr_stable", 32'(imem_addr), 32'h0400);
    imem_ack = 1'b1;
    imem_rdata = 16'h7777;
    exp_q.push_back({16'h7777, 16'h0402});
    tick();
    fetch_start = 1'b0;
    imem_ack = 1'b0;
    check("ign_pw", 32'(pc_write), 1);
    tick();
    check("ign_idle_req", 32'(imem_req), 0);
    tick();
    check("ign_no_refetch", 32'(imem_req), 0);

    // Reset asserted mid-REQ.
    pc = 16'h0600;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("mid_req_high", 32'(imem_req), 1);
    reset = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("mid_rst_req", 32'(imem_req), 0);
    check("mid_rst_addr", 32'(imem_addr), 0);
    check("mid_rst_ir", 32'(ir), 0);
    check("mid_rst_pc_next", 32'(pc_next), 0);
    check("mid_rst_strobes", {30'd0, pc_write, fetch_done}, 0);
    check("mid_rst_busy_fault", {30'd0, busy, fetch_fault}, 0);
    reset = 1'b0;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
